melody_sequencer: RTL and testbench

Downstream consumer of the clock manager's eight note square waves and QUARTER_BEAT. Plays a fixed 14-note melody from an internal ROM, stepping on QUARTER_BEAT rising edges and routing the selected note clock to the speaker pin. When idle, it gives live piano play from KEYS. A play/pause/stop FSM is driven by single-cycle button pulses, which upstream debouncers already provide.

---
 rtl/melody_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Fixed 14-note melody player stepping on QUARTER_BEAT rising edges, with
// play/pause/stop control and live keyboard play while idle.
module melody_sequencer #(
    parameter int GAP_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_C4,
    input  logic       CLK_D,
    input  logic       CLK_E,
    input  logic       CLK_F,
    input  logic       CLK_G,
    input  logic       CLK_A,
    input  logic       CLK_B,
    input  logic       CLK_C5,
    input  logic       QUARTER_BEAT,
    input  logic       PLAY_BTN,
    input  logic       STOP_BTN,
    input  logic [7:0] KEYS,
    output logic       SPEAKER,
    output logic [3:0] NOTE_IDX,
    output logic       PLAYING,
    output logic       SONG_DONE
);
    typedef enum logic [1:0] {ST_IDLE, ST_PLAYING, ST_PAUSED} state_t;

    localparam logic [7:0] GAP      = 8'(GAP_CYCLES);
    localparam logic [3:0] LAST_IDX = 4'd13;

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [1:0] beat_reg, beat_next;
    logic [7:0] gap_reg, gap_next;
    logic       qb_prev_reg;
    logic       done_next;
    logic       tick;
    logic [3:0] rom_note;
    logic [1:0] rom_beats;
    logic [3:0] key_note;
    logic [3:0] sel_note;
    logic       sel_spk;
    logic [7:0] note_clks;

    assign note_clks = {CLK_C5, CLK_B, CLK_A, CLK_G, CLK_F, CLK_E, CLK_D, CLK_C4};
    assign tick      = QUARTER_BEAT & ~qb_prev_reg;

    // Melody ROM: note code and length in beats per entry
    always_comb begin
        rom_note  = 4'd0;
        rom_beats = 2'd1;
        case (idx_reg)
            4'd0, 4'd1:   rom_note = 4'd1;
            4'd2, 4'd3:   rom_note = 4'd5;
            4'd4, 4'd5:   rom_note = 4'd6;
            4'd6: begin
                rom_note  = 4'd5;
                rom_beats = 2'd2;
            end
            4'd7, 4'd8:   rom_note = 4'd4;
            4'd9, 4'd10:  rom_note = 4'd3;
            4'd11, 4'd12: rom_note = 4'd2;
            4'd13: begin
                rom_note  = 4'd1;
                rom_beats = 2'd2;
            end
            default: begin
                rom_note  = 4'd0;
                rom_beats = 2'd1;
            end
        endcase
    end

    // Lowest set key wins: scan from the top so lower bits overwrite
    always_comb begin
        key_note = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (KEYS[i]) begin
                key_note = 4'(i + 1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        beat_next  = beat_reg;
        gap_next   = gap_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (PLAY_BTN) begin
                    state_next = ST_PLAYING;
                    idx_next   = 4'd0;
                    beat_next  = 2'd0;
                    gap_next   = GAP;
                end
            end
            ST_PLAYING: begin
                if (PLAY_BTN) begin
                    state_next = ST_PAUSED;
                end else begin
                    if (gap_reg != 8'd0) begin
                        gap_next = gap_reg - 8'd1;
                    end
                    if (tick) begin
                        if (beat_reg == rom_beats - 2'd1) begin
                            beat_next = 2'd0;
                            if (idx_reg == LAST_IDX) begin
                                state_next = ST_IDLE;
                                idx_next   = 4'd0;
                                gap_next   = 8'd0;
                                done_next  = 1'b1;
                            end else begin
                                idx_next = idx_reg + 4'd1;
                                gap_next = GAP;
                            end
                        end else begin
                            beat_next = beat_reg + 2'd1;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (PLAY_BTN) begin
                    state_next = ST_PLAYING;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (STOP_BTN) begin
            state_next = ST_IDLE;
            idx_next   = 4'd0;
            beat_next  = 2'd0;
            gap_next   = 8'd0;
            done_next  = 1'b0;
        end
    end

    always_comb begin
        sel_note = 4'd0;
        sel_spk  = 1'b0;
        case (state_reg)
            ST_IDLE:    sel_note = key_note;
            ST_PLAYING: sel_note = rom_note;
            ST_PAUSED:  sel_note = rom_note;
            default:    sel_note = 4'd0;
        endcase
        if (sel_note != 4'd0 && state_reg != ST_PAUSED && gap_reg == 8'd0) begin
            sel_spk = note_clks[3'(sel_note - 4'd1)];
        end
        // Articulation gap only applies to sequenced notes, never to live keys
        if (state_reg == ST_IDLE && sel_note != 4'd0) begin
            sel_spk = note_clks[3'(sel_note - 4'd1)];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 4'd0;
            beat_reg    <= 2'd0;
            gap_reg     <= 8'd0;
            qb_prev_reg <= 1'b0;
            SPEAKER     <= 1'b0;
            NOTE_IDX    <= 4'd0;
            PLAYING     <= 1'b0;
            SONG_DONE   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            beat_reg    <= beat_next;
            gap_reg     <= gap_next;
            qb_prev_reg <= QUARTER_BEAT;
            SPEAKER     <= sel_spk;
            NOTE_IDX    <= sel_note;
            PLAYING     <= (state_next == ST_PLAYING);
            SONG_DONE   <= done_next;
        end
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer against a beat-counting song model.
module tb_melody_sequencer;
    localparam int GAP = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] nclk;
    logic       QUARTER_BEAT, PLAY_BTN, STOP_BTN;
    logic [7:0] KEYS;
    logic       SPEAKER;
    logic [3:0] NOTE_IDX;
    logic       PLAYING, SONG_DONE;

    melody_sequencer #(.GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RESET(RESET),
        .CLK_C4(nclk[0]), .CLK_D(nclk[1]), .CLK_E(nclk[2]), .CLK_F(nclk[3]),
        .CLK_G(nclk[4]), .CLK_A(nclk[5]), .CLK_B(nclk[6]), .CLK_C5(nclk[7]),
        .QUARTER_BEAT(QUARTER_BEAT), .PLAY_BTN(PLAY_BTN), .STOP_BTN(STOP_BTN),
        .KEYS(KEYS), .SPEAKER(SPEAKER), .NOTE_IDX(NOTE_IDX),
        .PLAYING(PLAYING), .SONG_DONE(SONG_DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int song_note [14] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
    int song_len  [14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

    // Model: mode 0 idle, 1 playing, 2 paused; position in song, beats into note
    int   m_mode, m_pos, m_t, m_mute;
    logic m_qbp;
    logic exp_spk, exp_play, exp_done;
    int   exp_note;

    int   ncnt [8];
    int   hp   [8];
    int   qb_cnt, qb_rises, done_seen, g, r0;
    bit   qb_en, tick_fired;
    logic [7:0] keys_q;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_t = 0; m_mute = 0; m_qbp = 1'b0;
        exp_spk = 1'b0; exp_note = 0; exp_play = 1'b0; exp_done = 1'b0;
    endtask

    // Predicts the registered outputs after the coming rising clock edge
    task automatic model_step();
        logic       tick;
        logic [7:0] low;
        int         note;
        tick = QUARTER_BEAT && !m_qbp;
        case (m_mode)
            0: begin
                low      = KEYS & (~KEYS + 8'd1);
                exp_note = (low == 8'd0) ? 0 : $clog2(low) + 1;
                exp_spk  = |(nclk & low);
            end
            1: begin
                note     = song_note[m_pos];
                exp_note = note;
                exp_spk  = (m_mute > 0) ? 1'b0 : nclk[note - 1];
            end
            default: begin
                exp_note = song_note[m_pos];
                exp_spk  = 1'b0;
            end
        endcase
        exp_done = 1'b0;
        if (STOP_BTN) begin
            m_mode = 0; m_pos = 0; m_t = 0; m_mute = 0;
        end else if (PLAY_BTN) begin
            if (m_mode == 0) begin
                m_mode = 1; m_pos = 0; m_t = 0; m_mute = GAP;
            end else begin
                m_mode = (m_mode == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (m_mute > 0) m_mute--;
            if (tick) begin
                if (m_t + 1 == song_len[m_pos]) begin
                    m_t = 0;
                    if (m_pos == 13) begin
                        m_mode = 0; m_pos = 0; m_mute = 0; exp_done = 1'b1;
                    end else begin
                        m_pos++; m_mute = GAP;
                    end
                end else begin
                    m_t++;
                end
            end
        end
        exp_play = (m_mode == 1);
        m_qbp    = QUARTER_BEAT;
    endtask

    task automatic step(input bit play, input bit stop, input bit play_at_tick);
        @(negedge CLK);
        check_val("speaker", SPEAKER, exp_spk);
        check_val("note_idx", NOTE_IDX, exp_note);
        check_val("playing", PLAYING, exp_play);
        check_val("song_done", SONG_DONE, exp_done);
        if (SONG_DONE) done_seen++;
        for (int i = 0; i < 8; i++) begin
            ncnt[i]--;
            if (ncnt[i] == 0) begin
                nclk[i] = ~nclk[i];
                ncnt[i] = hp[i];
            end
        end
        if (qb_en) begin
            qb_cnt--;
            if (qb_cnt == 0) begin
                QUARTER_BEAT = ~QUARTER_BEAT;
                qb_cnt = $urandom_range(20, 40);
                if (QUARTER_BEAT) qb_rises++;
            end
        end
        KEYS     = keys_q;
        PLAY_BTN = play;
        STOP_BTN = stop;
        if (play_at_tick && QUARTER_BEAT && !m_qbp) begin
            PLAY_BTN   = 1'b1;
            tick_fired = 1'b1;
        end
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; QUARTER_BEAT = 1'b0; PLAY_BTN = 1'b0; STOP_BTN = 1'b0;
        KEYS = 8'd0; keys_q = 8'd0; nclk = 8'd0;
        qb_en = 1'b0; qb_cnt = 25; qb_rises = 0; done_seen = 0; tick_fired = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hp[i]   = $urandom_range(1, 6);
            ncnt[i] = hp[i];
        end
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_speaker", SPEAKER, 0);
        check_val("rst_note", NOTE_IDX, 0);
        check_val("rst_playing", PLAYING, 0);
        check_val("rst_done", SONG_DONE, 0);
        RESET = 1'b0;
        model_step();

        // Live keys in idle
        keys_q = 8'b0001_0100;
        run(30);
        check_val("key_e_note", NOTE_IDX, 3);
        keys_q = 8'd0;
        run(10);
        repeat (10) begin
            keys_q = 8'($urandom);
            run(6);
        end

        // Full song; keys must be ignored while playing
        keys_q = 8'($urandom) | 8'h01;
        qb_en = 1'b1; done_seen = 0; r0 = qb_rises;
        step(1'b1, 1'b0, 1'b0);
        g = 0;
        while (m_mode != 0 && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        run(3);
        check_val("song_end_playing", PLAYING, 0);
        check_val("song_done_count", done_seen, 1);
        check_val("edges_per_song", qb_rises - r0, 16);

        // Pause at idx 4, ticks ignored, resume
        keys_q = 8'd0;
        step(1'b1, 1'b0, 1'b0);
        g = 0;
        while (m_pos != 4 && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        check_val("reach_idx4", m_pos, 4);
        step(1'b1, 1'b0, 1'b0);
        r0 = qb_rises; g = 0;
        while (qb_rises < r0 + 3 && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        run(2);
        check_val("paused_note", NOTE_IDX, 6);
        check_val("paused_playing", PLAYING, 0);
        step(1'b1, 1'b0, 1'b0);
        r0 = qb_rises; g = 0;
        while (qb_rises < r0 + 2 && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        run(2);
        check_val("resumed_note", NOTE_IDX, 5);
        step(1'b0, 1'b1, 1'b0);

        // Stop during idx 9, then restart from the first note
        step(1'b1, 1'b0, 1'b0);
        g = 0;
        while (m_pos != 9 && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        step(1'b0, 1'b1, 1'b0);
        run(2);
        check_val("stop_note", NOTE_IDX, 0);
        check_val("stop_playing", PLAYING, 0);
        step(1'b1, 1'b0, 1'b0);
        run(2);
        check_val("restart_note", NOTE_IDX, 1);
        check_val("restart_playing", PLAYING, 1);

        // Play and stop together
        step(1'b0, 1'b1, 1'b0);
        run(2);
        step(1'b1, 1'b1, 1'b0);
        run(2);
        check_val("both_btn_playing", PLAYING, 0);
        check_val("both_btn_note", NOTE_IDX, 0);

        // Pause on the final tick: no completion pulse
        step(1'b1, 1'b0, 1'b0);
        g = 0;
        while (!(m_pos == 13 && m_t == 1) && g < 5000) begin step(1'b0, 1'b0, 1'b0); g++; end
        tick_fired = 1'b0; done_seen = 0; g = 0;
        while (!tick_fired && g < 500) begin step(1'b0, 1'b0, 1'b1); g++; end
        run(3);
        check_val("final_pause_playing", PLAYING, 0);
        check_val("final_pause_done", done_seen, 0);
        check_val("final_pause_note", NOTE_IDX, 1);
        step(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-note
        step(1'b1, 1'b0, 1'b0);
        run(100);
        #2 RESET = 1'b1;
        #1;
        check_val("async_rst_speaker", SPEAKER, 0);
        check_val("async_rst_note", NOTE_IDX, 0);
        check_val("async_rst_playing", PLAYING, 0);
        check_val("async_rst_done", SONG_DONE, 0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        model_step();

        // Random buttons and keys
        repeat (1500) begin
            if ($urandom_range(0, 15) == 0) keys_q = 8'($urandom);
            step($urandom_range(0, 60) == 0, $urandom_range(0, 200) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
